// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle ALU with one-cycle logic/arith ops and iterative shifts behind valid/ready handshakes
module alu_seq_exec #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_control,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         illegal
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state_q;
  logic [W-1:0]  acc_q, result_q;
  logic [SW-1:0] cnt_q;
  logic          left_q, zero_q, carry_q, illegal_q, out_valid_q;
  logic [W:0]    sum;
  logic [SW-1:0] amt;
  logic          is_shift, carry_d, illegal_d, out_bit;
  logic [W-1:0]  res_d, acc_d;
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign illegal   = illegal_q;
  // Single-cycle result for every op; shifts here only cover the zero-amount case
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    amt       = b[SW-1:0];
    is_shift  = alu_control == 4'b0111 || alu_control == 4'b1001;
    res_d     = '0;
    carry_d   = 1'b0;
    illegal_d = 1'b0;
    case (alu_control)
      4'b0000: {carry_d, res_d} = sum;
      4'b0001: begin res_d = a - b; carry_d = a >= b; end
      4'b0010: res_d = a & b;
      4'b0011: res_d = a | b;
      4'b0100: res_d = b;
      4'b0101: res_d = {{(W-1){1'b0}}, &a};
      4'b0110: res_d = {{(W-1){1'b0}}, |a};
      4'b0111, 4'b1001: res_d = a;
      4'b1000: res_d = a ^ b;
      default: illegal_d = 1'b1;
    endcase
  end
  // One-bit shift step of the accumulator and the bit that falls off the end
  always_comb begin
    acc_d   = left_q ? {acc_q[W-2:0], 1'b0} : {1'b0, acc_q[W-1:1]};
    out_bit = left_q ? acc_q[W-1] : acc_q[0];
  end
  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (is_shift && amt != '0) begin
            state_q <= SHIFT;
            cnt_q   <= amt;
            acc_q   <= a;
            left_q  <= alu_control == 4'b0111;
          end else begin
            state_q     <= DONE;
            result_q    <= res_d;
            zero_q      <= res_d == '0;
            carry_q     <= carry_d;
            illegal_q   <= illegal_d;
            out_valid_q <= 1'b1;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SW'(1)) begin
            state_q     <= DONE;
            result_q    <= acc_d;
            zero_q      <= acc_d == '0;
            carry_q     <= out_bit;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed and randomized checks of alu_seq_exec against a transaction-level model
module tb_alu_seq_exec;
  localparam int W = 8;
  logic         clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]   alu_control = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, zero, carry, illegal;
  logic [W-1:0] result;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;
  bit m_busy = 1'b0;
  int m_wait = 0;
  logic [W-1:0] m_r = '0;
  logic m_c = 1'b0, m_il = 1'b0;

  alu_seq_exec #(.W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .carry(carry),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operation semantics straight from the op table; lat = extra shift cycles
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic c, output logic il, output int lat);
    int n;
    logic [W:0] s;
    n = int'(y) % W;
    r = '0; c = 1'b0; il = 1'b0; lat = 0;
    case (op)
      4'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[W-1:0]; c = s[W]; end
      4'd1: begin r = x - y; c = x >= y; end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = y;
      4'd5: r = (x == {W{1'b1}}) ? 1 : 0;
      4'd6: r = (x != 0) ? 1 : 0;
      4'd7: begin r = x << n; c = (n > 0) ? x[W-n] : 1'b0; lat = n; end
      4'd8: r = x ^ y;
      4'd9: begin r = x >> n; c = (n > 0) ? x[n-1] : 1'b0; lat = n; end
      default: il = 1'b1;
    endcase
  endtask

  // One clock: drive inputs, advance the model at the edge, land just after the negedge
  task automatic cyc(input bit v, input logic [3:0] op, input logic [W-1:0] x,
                     input logic [W-1:0] y, input bit ordy);
    int lat;
    in_valid = v; alu_control = op; a = x; b = y; out_ready = ordy;
    @(posedge clk);
    if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        model_op(alu_control, a, b, m_r, m_c, m_il, lat);
        m_wait = lat;
      end
    end else if (m_wait > 0) m_wait--;
    else if (out_ready) m_busy = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    cyc(1'b0, 4'd0, '0, '0, 1'b1);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    m_busy = 1'b0; m_wait = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, carry, illegal}, 0);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // Every cycle: handshake outputs always, payload whenever a result is presented
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_busy && m_wait == 0);
      if (m_busy && m_wait == 0) begin
        chk("result", result, m_r);
        chk("zero", zero, m_r == 0);
        chk("carry", carry, m_c);
        chk("illegal", illegal, m_il);
      end
    end
  end

  initial begin
    logic [W-1:0] r;
    logic c, il;
    int lat;
    model_op(4'd0, 8'hF0, 8'h20, r, c, il, lat);
    chk("model_add", {r, c, il}, {8'h10, 1'b1, 1'b0});
    model_op(4'd7, 8'h81, 8'h03, r, c, il, lat);
    chk("model_sll", {r, c, 8'(lat)}, {8'h08, 1'b0, 8'd3});
    model_op(4'd9, 8'h81, 8'hF1, r, c, il, lat);
    chk("model_srl", {r, c, 8'(lat)}, {8'h40, 1'b1, 8'd1});
    model_op(4'd12, 8'h33, 8'h44, r, c, il, lat);
    chk("model_ill", {r, c, il}, {8'h00, 1'b0, 1'b1});
    #12 reset = 1'b0;
    @(negedge clk);
    #1 chk_on = 1'b1;
    do_reset();
    cyc(1'b1, 4'd0, 8'hF0, 8'h20, 1'b0);
    chk("add_valid", out_valid, 1);
    chk("add_res", {result, carry, zero}, {8'h10, 1'b1, 1'b0});
    drain();
    cyc(1'b1, 4'd1, 8'h05, 8'h05, 1'b0);
    chk("sub_res", {result, carry, zero}, {8'h00, 1'b1, 1'b1});
    drain();
    cyc(1'b1, 4'd7, 8'h81, 8'h03, 1'b0);
    chk("sll_busy0", {in_ready, out_valid}, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      chk("sll_busy", {in_ready, out_valid}, 0);
    end
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("sll_res", {out_valid, result, carry}, {1'b1, 8'h08, 1'b0});
    drain();
    cyc(1'b1, 4'd9, 8'h81, 8'hF1, 1'b0);
    chk("srl_busy", out_valid, 0);
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    chk("srl_res", {out_valid, result, carry}, {1'b1, 8'h40, 1'b1});
    drain();
    cyc(1'b1, 4'd3, 8'h0F, 8'h30, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 4'd0, 8'hAA, 8'h55, 1'b0);
      chk("bp_hold", {out_valid, in_ready, result, carry, zero}, {1'b1, 1'b0, 8'h3F, 1'b0, 1'b0});
    end
    cyc(1'b1, 4'd0, 8'hAA, 8'h55, 1'b1);
    chk("bp_release", {out_valid, in_ready}, {1'b0, 1'b1});
    cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
    cyc(1'b1, 4'd12, 8'h12, 8'h34, 1'b0);
    chk("ill_res", {result, illegal, zero}, {8'h00, 1'b1, 1'b1});
    drain();
    cyc(1'b1, 4'd5, 8'hFF, 8'h00, 1'b0);
    chk("andr_res", {result, illegal}, {8'h01, 1'b0});
    drain();
    cyc(1'b1, 4'd7, 8'h01, 8'h07, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'd0, 8'h00, 8'h00, 1'b1);
      chk("rst_shift_quiet", out_valid, 0);
    end
    cyc(1'b1, 4'd8, 8'hC3, 8'h0F, 1'b0);
    chk("post_rst_op", {out_valid, result}, {1'b1, 8'hCC});
    drain();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
          $urandom_range(0, 9) < 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Multi-cycle ALU execution unit. It consumes the 4-bit ALUControl code produced by the ALU decoder, together with two operands, and returns a registered result with flags.
- Logic and arithmetic ops complete in one cycle.
- Shifts run iteratively, one bit position per cycle.
- Sits between operand fetch and writeback. Valid/ready handshakes on both sides let the control FSM stall on long shifts.

Parameters:
W, 8, datapath width in bits (power of two, >=4)
SW, $clog2(W), shift-amount field width taken from b[SW-1:0]

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operands and alu_control present
in_ready  output  1  unit idle and able to accept
alu_control  input  4  operation code (encoding below)
a  input  W  operand A / shift source
b  input  W  operand B / shift amount in b[SW-1:0]
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  W  registered result
zero  output  1  result == 0
carry  output  1  carry / no-borrow / last bit shifted out
illegal  output  1  alu_control was an undefined code

Behaviour:
Reset and state machine
- Async reset: state=IDLE; result, zero, carry, illegal, out_valid = 0; shift counter and accumulator = 0.
- in_ready = (state==IDLE), so it is 1 during and after reset.
- Reset mid-SHIFT or mid-DONE discards the operation with no output.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: accept on in_valid&&in_ready and latch alu_control/a/b.
    - Non-shift or zero-amount shift: go to DONE, result registered on that edge, so out_valid=1 the next cycle (latency 1).
    - Shift with amount n>0: go to SHIFT with count=n, acc=a.
  - SHIFT: each cycle acc shifts by 1 and count decrements. When count==1 on an edge, result=shifted acc and go to DONE. Total latency 1+n cycles; in_ready=0 throughout.
  - DONE: out_valid=1. result/flags held stable while out_ready=0. On out_ready=1, go to IDLE and drop out_valid the next cycle. New input is not accepted in the same cycle as the DONE handshake.

Operations (carry defined per op; illegal=0 except undefined codes)
- 0000 add: {carry,result}=a+b (W+1-bit sum).
- 0001 sub: result=a-b mod 2^W; carry=1 iff a>=b unsigned (no borrow).
- 0010 and: a&b; carry=0.
- 0011 or: a|b; carry=0.
- 0100 pass: result=b; carry=0.
- 0101 and-reduce: result={W-1 zeros, &a}; carry=0.
- 0110 or-reduce: result={W-1 zeros, |a}; carry=0.
- 0111 shift left logical by b[SW-1:0]: zero fill; carry=last bit shifted out of MSB.
- 1000 xor: a^b; carry=0.
- 1001 shift right logical by b[SW-1:0]: zero fill; carry=last bit shifted out of LSB.
- Shift boundaries: upper bits of b above SW are ignored. Amount 0 gives result=a, carry=0, 1-cycle latency.
- 1010-1111 undefined: result=0, carry=0, illegal=1, 1-cycle latency.
- zero is computed from the final result for every op.

Handshake
- Inputs are sampled only on the accept edge; input changes while busy have no effect.
- in_valid held high while busy stays pending and is accepted on the first IDLE cycle.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> out_valid=0, result=0, flags=0, in_ready=1 immediately.
- add a=8'hF0, b=8'h20 -> one cycle later out_valid=1, result=8'h10, carry=1, zero=0; sub a=8'h05, b=8'h05 -> result=0, zero=1, carry=1.
- Shift left a=8'h81, b=8'h03 -> in_ready=0 for 3 cycles, out_valid at cycle 4, result=8'h08, carry=0; shift right a=8'h81, b=8'hF1 (amount 1) -> result=8'h40, carry=1, latency 2.
- Backpressure: out_ready=0 for 5 cycles after a completed or op -> result/flags stable, in_ready=0; out_ready=1 -> out_valid falls next cycle, in_ready rises.
- Illegal code 4'b1100 -> result=0, illegal=1, zero=1; a following and-reduce a=8'hFF -> result=8'h01, illegal=0.
- Reset asserted during SHIFT with amount 7 -> no out_valid pulse; next op accepted normally.
